// File: rtl/client_axis_tx.sv
// -----------------------------------------------------------------------------
// client_axis_tx
//
// Buffers addends pushed by a client and replays them as an AXI-Stream
// transaction. Each addend is zero-extended to the stream width. The addend
// flagged with tlast closes the transaction: once that beat is accepted the
// block parks in DONE until the client pulses client_restart.
//
// Widths normally come from static_params.vh (DATAW, AXIS_MAX_DATAW). Local
// defaults (128 / 512) are used when those macros are not already defined.
//
// Optional feature: define CLIENT_SENT_SUM_EN to add client_sent_sum, a
// modulo-2^DATAW running sum of the addends carried by accepted beats.
//
// Parameters
//   FIFO_DEPTH     addend buffer entries (power of two, >= 2)
//
// Ports
//   clk                           sole clock, all state on posedge
//   rst                           synchronous active-high reset
//   client_tdata_in   [DATAW]     addend to send
//   client_tlast_in               marks final addend of the transaction
//   client_valid_in               push request
//   client_ready_out              buffer can accept a push
//   client_restart                single-cycle pulse, leaves DONE
//   axis_client_interface_tvalid  stream data valid
//   axis_client_interface_tlast   final beat
//   axis_client_interface_tdata   stream data [AXIS_MAX_DATAW]
//   axis_client_interface_tready  receiver ready
//   client_sent_count [16]        beats accepted since reset/restart
//   client_sent_sum   [DATAW]     (CLIENT_SENT_SUM_EN only) sum of sent addends
// -----------------------------------------------------------------------------
`ifndef DATAW
`define DATAW 128
`endif
`ifndef AXIS_MAX_DATAW
`define AXIS_MAX_DATAW 512
`endif

module client_axis_tx #(
   parameter int FIFO_DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [`DATAW-1:0]          client_tdata_in,
   input  logic                       client_tlast_in,
   input  logic                       client_valid_in,
   output logic                       client_ready_out,
   input  logic                       client_restart,
   output logic                       axis_client_interface_tvalid,
   output logic                       axis_client_interface_tlast,
   output logic [`AXIS_MAX_DATAW-1:0] axis_client_interface_tdata,
   input  logic                       axis_client_interface_tready,
   output logic [15:0]                client_sent_count
`ifdef CLIENT_SENT_SUM_EN
   ,
   output logic [`DATAW-1:0]          client_sent_sum
`endif
);

   localparam int DW   = `DATAW;
   localparam int AXW  = `AXIS_MAX_DATAW;
   localparam int PTRW = $clog2(FIFO_DEPTH);
   localparam int CNTW = PTRW + 1;
   localparam int OCCW = CNTW + 1;

   localparam logic [PTRW-1:0] PTR_ONE = PTRW'(1);
   localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
   localparam logic [OCCW-1:0] OCC_MAX = OCCW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Each entry stores {tlast, addend}.
   logic [DW:0]     fifo_mem [FIFO_DEPTH];

   state_e          state_q,     state_d;
   logic [PTRW-1:0] wr_ptr_q,    wr_ptr_d;
   logic [PTRW-1:0] rd_ptr_q,    rd_ptr_d;
   logic [CNTW-1:0] fifo_cnt_q,  fifo_cnt_d;
   logic            out_valid_q, out_valid_d;
   logic            out_last_q,  out_last_d;
   logic [DW-1:0]   out_data_q,  out_data_d;
   logic            last_pend_q, last_pend_d;
   logic            ready_q,     ready_d;
   logic [15:0]     sent_cnt_q,  sent_cnt_d;
`ifdef CLIENT_SENT_SUM_EN
   logic [DW-1:0]   sum_q,       sum_d;
`endif

   logic            push_s;
   logic            hs_s;
   logic            load_s;
   logic            restart_s;
   logic [OCCW-1:0] occ_d_s;

   // Next-state, datapath and FSM decisions for every register.
   always_comb begin
      push_s    = client_valid_in && ready_q;
      hs_s      = out_valid_q && axis_client_interface_tready;
      restart_s = client_restart && (state_q == ST_DONE);
      // The output register refills from the FIFO head when it is empty or
      // its current beat is leaving; nothing follows a tlast beat.
      load_s    = (fifo_cnt_q != {CNTW{1'b0}}) && (state_q != ST_DONE) &&
                  (!out_valid_q || (hs_s && !out_last_q));

      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      fifo_cnt_d  = fifo_cnt_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_data_d  = out_data_q;
      last_pend_d = last_pend_q;
      sent_cnt_d  = sent_cnt_q;
`ifdef CLIENT_SENT_SUM_EN
      sum_d       = sum_q;
`endif

      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (load_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, load_s})
         2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_ONE;
         2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_ONE;
         default: fifo_cnt_d = fifo_cnt_q;
      endcase

      // Beats only change on load or departure, so they stay stable while stalled.
      if (load_s) begin
         out_valid_d = 1'b1;
         out_last_d  = fifo_mem[rd_ptr_q][DW];
         out_data_d  = fifo_mem[rd_ptr_q][DW-1:0];
      end else if (hs_s) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
         out_data_d  = {DW{1'b0}};
      end else begin
         out_valid_d = out_valid_q;
         out_last_d  = out_last_q;
         out_data_d  = out_data_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (load_s) begin
               state_d = ST_SEND;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SEND: begin
            if (hs_s && out_last_q) begin
               state_d = ST_DONE;
            end else if (hs_s && !load_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_SEND;
            end
         end
         ST_DONE: begin
            if (restart_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Once a tlast addend is accepted the transaction is closed to new pushes.
      if (restart_s) begin
         last_pend_d = 1'b0;
      end else if (push_s && client_tlast_in) begin
         last_pend_d = 1'b1;
      end else begin
         last_pend_d = last_pend_q;
      end

      if (restart_s) begin
         sent_cnt_d = 16'd0;
      end else if (hs_s && (sent_cnt_q != 16'hFFFF)) begin
         sent_cnt_d = sent_cnt_q + 16'd1;
      end else begin
         sent_cnt_d = sent_cnt_q;
      end

`ifdef CLIENT_SENT_SUM_EN
      if (restart_s) begin
         sum_d = {DW{1'b0}};
      end else if (hs_s) begin
         sum_d = sum_q + out_data_q;
      end else begin
         sum_d = sum_q;
      end
`endif

      // Occupancy counts the output register too, so FIFO_DEPTH addends in
      // total can be outstanding. Ready is registered: a pop frees space for
      // the following cycle, never the same one.
      occ_d_s = OCCW'(fifo_cnt_d) + OCCW'(out_valid_d);
      ready_d = (state_d != ST_DONE) && !last_pend_d && (occ_d_s < OCC_MAX);
   end

   // Addend storage; stale entries are unreachable once the pointers reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_mem[wr_ptr_q] <= {client_tlast_in, client_tdata_in};
      end
   end

   // Control and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= {PTRW{1'b0}};
         rd_ptr_q    <= {PTRW{1'b0}};
         fifo_cnt_q  <= {CNTW{1'b0}};
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= {DW{1'b0}};
         last_pend_q <= 1'b0;
         ready_q     <= 1'b0;
         sent_cnt_q  <= 16'd0;
`ifdef CLIENT_SENT_SUM_EN
         sum_q       <= {DW{1'b0}};
`endif
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         fifo_cnt_q  <= fifo_cnt_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
         last_pend_q <= last_pend_d;
         ready_q     <= ready_d;
         sent_cnt_q  <= sent_cnt_d;
`ifdef CLIENT_SENT_SUM_EN
         sum_q       <= sum_d;
`endif
      end
   end

   assign client_ready_out             = ready_q;
   assign axis_client_interface_tvalid = out_valid_q;
   assign axis_client_interface_tlast  = out_last_q;
   assign axis_client_interface_tdata  = AXW'(out_data_q);
   assign client_sent_count            = sent_cnt_q;
`ifdef CLIENT_SENT_SUM_EN
   assign client_sent_sum              = sum_q;
`endif

endmodule

// File: tb/tb_client_axis_tx.sv
// -----------------------------------------------------------------------------
// tb_client_axis_tx
//
// Self-checking bench for client_axis_tx. Push vectors come from a table; every
// beat the block should emit is queued in a scoreboard when its addend is
// pushed and compared when the beat is accepted. Inputs change 1 time unit
// after posedge; outputs are sampled on negedge.
// -----------------------------------------------------------------------------
`ifndef DATAW
`define DATAW 128
`endif
`ifndef AXIS_MAX_DATAW
`define AXIS_MAX_DATAW 512
`endif

module tb_client_axis_tx;

   localparam int DW  = `DATAW;
   localparam int AXW = `AXIS_MAX_DATAW;

   logic           clk = 1'b0;
   logic           rst;
   logic [DW-1:0]  tdata_in;
   logic           tlast_in;
   logic           valid_in;
   logic           ready_out;
   logic           restart;
   logic           tvalid;
   logic           tlast;
   logic [AXW-1:0] tdata;
   logic           tready;
   logic [15:0]    sent_count;
`ifdef CLIENT_SENT_SUM_EN
   logic [DW-1:0]  sent_sum;
`endif

   client_axis_tx #(.FIFO_DEPTH(16)) dut (
      .clk                          (clk),
      .rst                          (rst),
      .client_tdata_in              (tdata_in),
      .client_tlast_in              (tlast_in),
      .client_valid_in              (valid_in),
      .client_ready_out             (ready_out),
      .client_restart               (restart),
      .axis_client_interface_tvalid (tvalid),
      .axis_client_interface_tlast  (tlast),
      .axis_client_interface_tdata  (tdata),
      .axis_client_interface_tready (tready),
      .client_sent_count            (sent_count)
`ifdef CLIENT_SENT_SUM_EN
      ,
      .client_sent_sum              (sent_sum)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0]  addend;
      logic           last;
      logic           exp_ready;
      logic           exp_beat;
      logic [AXW-1:0] exp_tdata;
      logic           exp_tlast;
   } vec_t;

   vec_t         vtab [20];
   logic [AXW:0] sb [$];
   int           beat_cyc [$];
   int           n_checks = 0;
   int           n_fail   = 0;
   int           cyc_cnt  = 0;
   int           beats_seen = 0;
   logic         mon_en = 1'b0;

   task automatic check(input string name, input logic [AXW-1:0] act, input logic [AXW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [DW-1:0] a, input logic l, input logic er, input logic eb);
      vec_t v;
      v.addend    = a;
      v.last      = l;
      v.exp_ready = er;
      v.exp_beat  = eb;
      v.exp_tdata = eb ? AXW'(a) : {AXW{1'b0}};
      v.exp_tlast = eb & l;
      return v;
   endfunction

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_push(input logic [DW-1:0] d, input logic l);
      valid_in = 1'b1;
      tdata_in = d;
      tlast_in = l;
      cyc(1);
      valid_in = 1'b0;
      tdata_in = {DW{1'b0}};
      tlast_in = 1'b0;
   endtask

   task automatic expect_beat(input logic [DW-1:0] d, input logic l);
      sb.push_back({l, AXW'(d)});
   endtask

   task automatic apply(input int first, input int last_i);
      for (int i = first; i <= last_i; i++) begin
         check($sformatf("ready_before_push%0d", i), AXW'(ready_out), AXW'(vtab[i].exp_ready));
         if (vtab[i].exp_beat) begin
            sb.push_back({vtab[i].exp_tlast, vtab[i].exp_tdata});
         end
         do_push(vtab[i].addend, vtab[i].last);
      end
   endtask

   task automatic wait_empty(input int max_cyc, input string name);
      int i = 0;
      while (sb.size() != 0 && i < max_cyc) begin
         cyc(1);
         i++;
      end
      check(name, AXW'(sb.size()), AXW'(0));
   endtask

   task automatic check_no_bubbles(input string name, input int n);
      int gaps = 0;
      for (int i = 1; i < beat_cyc.size(); i++) begin
         if (beat_cyc[i] != beat_cyc[i-1] + 1) gaps++;
      end
      check({name, "_beats"}, AXW'(beat_cyc.size()), AXW'(n));
      check({name, "_bubbles"}, AXW'(gaps), AXW'(0));
   endtask

   task automatic pulse_restart();
      restart = 1'b1;
      cyc(1);
      restart = 1'b0;
   endtask

   // Cycle counter used to time-stamp accepted beats.
   initial begin
      forever begin
         @(posedge clk);
         cyc_cnt++;
      end
   end

   // Beat monitor: scoreboard compare, stall stability and idle-zero checks.
   initial begin
      logic           prev_stall;
      logic [AXW-1:0] prev_data;
      logic           prev_last;
      logic [AXW:0]   exp;
      prev_stall = 1'b0;
      prev_data  = {AXW{1'b0}};
      prev_last  = 1'b0;
      forever begin
         @(negedge clk);
         if (mon_en && !rst) begin
            if (prev_stall) begin
               check("stall_tvalid", AXW'(tvalid), AXW'(1'b1));
               check("stall_tdata", tdata, prev_data);
               check("stall_tlast", AXW'(tlast), AXW'(prev_last));
            end
            if (tvalid && tready) begin
               beats_seen++;
               beat_cyc.push_back(cyc_cnt);
               if (sb.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_beat: actual tdata %0h, required no beat", tdata);
               end else begin
                  exp = sb.pop_front();
                  check("beat_tdata", tdata, exp[AXW-1:0]);
                  check("beat_tlast", AXW'(tlast), AXW'(exp[AXW]));
               end
            end else if (!tvalid) begin
               check("idle_tdata", tdata, {AXW{1'b0}});
               check("idle_tlast", AXW'(tlast), AXW'(1'b0));
            end
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            prev_last  = tlast;
         end else begin
            prev_stall = 1'b0;
         end
      end
   end

   // Global time limit.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      int            b0;
      logic [DW-1:0] all_ones;

      // A: 5, 7, 9(last). B: 16 addends then a 17th that must be dropped.
      vtab[0] = mk(DW'(5), 1'b0, 1'b1, 1'b1);
      vtab[1] = mk(DW'(7), 1'b0, 1'b1, 1'b1);
      vtab[2] = mk(DW'(9), 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 16; i++) begin
         vtab[3+i] = mk(DW'(100 + i), 1'b0, 1'b1, 1'b1);
      end
      vtab[19] = mk(DW'(999), 1'b0, 1'b0, 1'b0);

      rst      = 1'b1;
      tdata_in = {DW{1'b0}};
      tlast_in = 1'b0;
      valid_in = 1'b0;
      restart  = 1'b0;
      tready   = 1'b0;

      // Reset state
      cyc(3);
      check("ready_in_rst", AXW'(ready_out), AXW'(1'b0));
      check("rst_tvalid", AXW'(tvalid), AXW'(1'b0));
      check("rst_tdata", tdata, {AXW{1'b0}});
      check("rst_count", AXW'(sent_count), AXW'(0));
      rst    = 1'b0;
      mon_en = 1'b1;
      cyc(1);
      check("ready_after_rst", AXW'(ready_out), AXW'(1'b1));

      // A: short transaction with receiver always ready
      tready = 1'b1;
      beat_cyc.delete();
      apply(0, 2);
      wait_empty(20, "drain_A");
      check_no_bubbles("A", 3);
      check("count_A", AXW'(sent_count), AXW'(3));
`ifdef CLIENT_SENT_SUM_EN
      check("sum_A", AXW'(sent_sum), AXW'(21));
`endif
      check("ready_done_A", AXW'(ready_out), AXW'(1'b0));
      check("tvalid_done_A", AXW'(tvalid), AXW'(1'b0));
      pulse_restart();
      check("count_restart", AXW'(sent_count), AXW'(0));
      check("ready_restart", AXW'(ready_out), AXW'(1'b1));

      // B: fill to capacity while stalled, then drain back-to-back
      tready = 1'b0;
      apply(3, 19);
      check("head_tvalid_B", AXW'(tvalid), AXW'(1'b1));
      check("head_tdata_B", tdata, AXW'(100));
      beat_cyc.delete();
      b0 = beats_seen;
      tready = 1'b1;
      wait_empty(40, "drain_B");
      cyc(3);
      check_no_bubbles("B", 16);
      check("beats_B", AXW'(beats_seen - b0), AXW'(16));
      check("count_B", AXW'(sent_count), AXW'(16));
      check("ready_idle_B", AXW'(ready_out), AXW'(1'b1));
      pulse_restart();
      check("restart_ignored", AXW'(sent_count), AXW'(16));

      // Plain reset between transactions
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      cyc(1);
      check("count_after_rst", AXW'(sent_count), AXW'(0));

      // C: receiver toggling ready on a 4-beat transaction
      tready = 1'b0;
      b0 = beats_seen;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("ready_C%0d", i), AXW'(ready_out), AXW'(1'b1));
         expect_beat(DW'(8'h11 + i), (i == 3));
         do_push(DW'(8'h11 + i), (i == 3));
      end
      for (int i = 0; i < 30 && sb.size() != 0; i++) begin
         tready = ~tready;
         cyc(1);
      end
      check("drain_C", AXW'(sb.size()), AXW'(0));
      tready = 1'b0;
      check("beats_C", AXW'(beats_seen - b0), AXW'(4));
      check("count_C", AXW'(sent_count), AXW'(4));
      check("ready_done_C", AXW'(ready_out), AXW'(1'b0));

      // D: sum wrap and zero-extension of a full-width addend
      pulse_restart();
      all_ones = {DW{1'b1}};
      tready = 1'b1;
      expect_beat(all_ones, 1'b0);
      do_push(all_ones, 1'b0);
      expect_beat(DW'(2), 1'b1);
      do_push(DW'(2), 1'b1);
      wait_empty(20, "drain_D");
      check("count_D", AXW'(sent_count), AXW'(2));
`ifdef CLIENT_SENT_SUM_EN
      check("sum_wrap_D", AXW'(sent_sum), AXW'(1));
`endif

      // Push in DONE is dropped; restart re-opens the channel
      check("ready_in_done", AXW'(ready_out), AXW'(1'b0));
      b0 = beats_seen;
      do_push(DW'(77), 1'b1);
      cyc(4);
      check("done_push_dropped", AXW'(beats_seen - b0), AXW'(0));
      check("done_tvalid", AXW'(tvalid), AXW'(1'b0));
      pulse_restart();
      check("count_restart_D", AXW'(sent_count), AXW'(0));
      check("ready_restart_D", AXW'(ready_out), AXW'(1'b1));
`ifdef CLIENT_SENT_SUM_EN
      check("sum_restart_D", AXW'(sent_sum), AXW'(0));
`endif
      expect_beat(DW'(42), 1'b1);
      do_push(DW'(42), 1'b1);
      wait_empty(20, "drain_after_restart");
      check("count_after_restart", AXW'(sent_count), AXW'(1));

      // E: reset mid-transaction discards buffered addends
      pulse_restart();
      tready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         expect_beat(DW'(8'h21 + i), 1'b0);
         do_push(DW'(8'h21 + i), 1'b0);
      end
      check("tvalid_before_rst_E", AXW'(tvalid), AXW'(1'b1));
      rst    = 1'b1;
      tready = 1'b1;
      cyc(1);
      sb.delete();
      check("tvalid_rst_E", AXW'(tvalid), AXW'(1'b0));
      check("tdata_rst_E", tdata, {AXW{1'b0}});
      check("count_rst_E", AXW'(sent_count), AXW'(0));
      check("ready_rst_E", AXW'(ready_out), AXW'(1'b0));
      b0 = beats_seen;
      cyc(1);
      rst = 1'b0;
      cyc(1);
      check("ready_after_rst_E", AXW'(ready_out), AXW'(1'b1));
      cyc(8);
      check("no_beats_after_rst_E", AXW'(beats_seen - b0), AXW'(0));
      check("count_after_rst_E", AXW'(sent_count), AXW'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/client_axis_tx.md
CLIENT_AXIS_TX -- requirements
Module: client_axis_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, addend buffer entries (power of two, >=2).
REQ-002 SHALL take widths from static_params.vh macros: DATAW (addend width) and AXIS_MAX_DATAW (stream width, >= DATAW).
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock, all state on posedge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 client_tdata_in  input  DATAW  addend to send.
REQ-007 client_tlast_in  input  1  marks final addend of transaction.
REQ-008 client_valid_in  input  1  push request.
REQ-009 client_ready_out  output  1  buffer can accept push.
REQ-010 client_restart  input  1  single-cycle pulse, leaves DONE.
REQ-011 axis_client_interface_tvalid  output  1  stream data valid.
REQ-012 axis_client_interface_tlast  output  1  final beat.
REQ-013 axis_client_interface_tdata  output  AXIS_MAX_DATAW  stream data.
REQ-014 axis_client_interface_tready  input  1  receiver ready.
REQ-015 client_sent_count  output  16  beats accepted since reset/restart.

Function
REQ-016 Push SHALL occur on posedge when client_valid_in && client_ready_out; pushes with ready low SHALL be dropped.
REQ-017 client_ready_out SHALL be 1 only when FIFO not full, state is not DONE, and no tlast addend is buffered or in the output register.
REQ-018 Beat handshake SHALL occur on posedge when tvalid && tready.
REQ-019 Output register SHALL load the FIFO head when empty or on handshake; push into empty FIFO/output at edge N SHALL give tvalid=1 after edge N+1.
REQ-020 Once tvalid=1, tvalid, tdata, tlast SHALL hold stable until handshake.
REQ-021 tdata SHALL be the addend zero-extended to AXIS_MAX_DATAW; tvalid=0 SHALL drive tdata=0, tlast=0.
REQ-022 Back-to-back: with tready held 1 and FIFO non-empty, one beat per cycle, no bubbles.
REQ-023 Simultaneous push and pop on full FIFO SHALL be permitted only via pop freeing space next cycle (ready is registered from current occupancy; no same-cycle pass-through).
REQ-024 FSM states: IDLE (no valid output), SEND (tvalid=1), DONE (tlast beat accepted).
REQ-025 IDLE->SEND when output register loads; SEND->IDLE on handshake of non-last beat with FIFO empty; SEND stays SEND on non-last handshake with FIFO non-empty; SEND->DONE on handshake with tlast=1.
REQ-026 DONE SHALL hold tvalid=0 and ready=0; client_restart in DONE SHALL go to IDLE and clear client_sent_count; client_restart outside DONE SHALL be ignored.
REQ-027 client_sent_count SHALL increment per handshake and saturate at 16'hFFFF.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter SHALL range 0..FIFO_DEPTH.

Reset
REQ-029 rst SHALL clear FIFO, pointers, output register, count, sum; state IDLE; tvalid=0, tlast=0, tdata=0.
REQ-030 client_ready_out SHALL be 0 while rst=1 and 1 the cycle after rst deasserts.
REQ-031 rst mid-transaction SHALL drop tvalid at that edge, discarding buffered addends regardless of tready.

Configuration
REQ-032 Macro CLIENT_SENT_SUM_EN SHALL, when defined, add output client_sent_sum [DATAW-1:0]: modulo-2^DATAW sum of tdata[DATAW-1:0] over accepted beats, cleared by rst and restart.
REQ-033 Without CLIENT_SENT_SUM_EN the port and adder SHALL be absent; all other behaviour identical.

Verification (DATAW=128, AXIS_MAX_DATAW=512, FIFO_DEPTH=16)
REQ-034 Push 5,7,9(last), tready=1 -> beats 5,7,9 consecutive, tlast only on 9, state DONE, count=3, sum=21.
REQ-035 Push 16 addends, tready=0 -> ready_out=0 after 16th push, 17th push dropped; tready=1 -> 16 beats in order, no bubbles.
REQ-036 tready toggled 1/0 each cycle during 4-beat send -> tdata/tlast stable while stalled, 4 handshakes, count=4.
REQ-037 Push 2^128-1 and 2(last) -> sum=1 (wrap), tdata upper 384 bits zero.
REQ-038 rst asserted while tvalid=1, 3 entries buffered -> tvalid=0 next edge, count=0, no further beats.
REQ-039 In DONE, push attempted -> dropped; client_restart pulse -> IDLE, count=0, next push sent normally.
